// File: rtl/rv_data_mem.sv
// Byte-addressed little-endian RV32I data memory: sw/sh/sb with lane placement from addr LSBs.
// Writes land on the rising edge; reads return the aligned word combinationally.
module rv_data_mem #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  input  logic        mem_wr,
  input  logic [1:0]  mux_store,
  output logic [31:0] data_out
);

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic [3:0]    be;
  logic [31:0]   wdat;
  logic          unused_addr;

  assign idx         = addr[AW+1:2];
  assign unused_addr = ^addr[31:AW+2];

  // Store data is replicated/shifted so each enabled lane already sees its own byte.
  always_comb begin
    be   = 4'b0000;
    wdat = 32'h0;
    case (mux_store)
      2'b01: begin
        if (addr[1]) begin
          be   = 4'b1100;
          wdat = {data_in[15:0], 16'h0000};
        end else begin
          be   = 4'b0011;
          wdat = {16'h0000, data_in[15:0]};
        end
      end
      2'b10: begin
        be   = 4'b0001 << addr[1:0];
        wdat = {4{data_in[7:0]}};
      end
      default: begin
        be   = 4'b1111;
        wdat = data_in;
      end
    endcase
  end

  for (genvar w = 0; w < DEPTH_WORDS; w++) begin : g_word
    logic sel;
    assign sel = mem_wr && (idx == AW'(w));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem[w] <= 32'h0;
      end else if (sel) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mem[w][8*b +: 8] <= wdat[8*b +: 8];
        end
      end
    end
  end

  assign data_out = mem[idx];

endmodule

// File: tb/tb_rv_data_mem.sv
// Directed self-checking bench for rv_data_mem.
module tb_rv_data_mem;
  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic        mem_wr;
  logic [1:0]  mux_store;
  logic [31:0] data_out;

  int checks = 0;
  int errors = 0;

  rv_data_mem #(.DEPTH_WORDS(256), .AW(8)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .data_in(data_in),
    .mem_wr(mem_wr), .mux_store(mux_store), .data_out(data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] ms);
    addr = a; data_in = d; mux_store = ms; mem_wr = 1'b1;
    @(posedge clk);
    #1;
    mem_wr = 1'b0;
  endtask

  task automatic set_addr(input logic [31:0] a);
    addr = a;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_wr = 1'b0; addr = 32'h0; data_in = 32'h0; mux_store = 2'b00;
    #2;
    set_addr(32'h10);
    checks++;
    if (data_out !== 32'h0) begin errors++; $display("FAIL reset_init: got %h want %h", data_out, 32'h0); end
    set_addr(32'h3FC);
    checks++;
    if (data_out !== 32'h0) begin errors++; $display("FAIL reset_init_top: got %h want %h", data_out, 32'h0); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_write(32'h10, 32'hDEADBEEF, 2'b00);
    set_addr(32'h10);
    checks++;
    if (data_out !== 32'hDEADBEEF) begin errors++; $display("FAIL reset_prewrite: got %h want %h", data_out, 32'hDEADBEEF); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (data_out !== 32'h0) begin errors++; $display("FAIL reset_async_clear: got %h want %h", data_out, 32'h0); end
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (data_out !== 32'h0) begin errors++; $display("FAIL reset_after_release: got %h want %h", data_out, 32'h0); end
  endtask

  task automatic test_word();
    do_write(32'h20, 32'h12345678, 2'b00);
    set_addr(32'h20);
    checks++;
    if (data_out !== 32'h12345678) begin errors++; $display("FAIL word_rd20: got %h want %h", data_out, 32'h12345678); end
    set_addr(32'h21);
    checks++;
    if (data_out !== 32'h12345678) begin errors++; $display("FAIL word_rd21: got %h want %h", data_out, 32'h12345678); end
    set_addr(32'h23);
    checks++;
    if (data_out !== 32'h12345678) begin errors++; $display("FAIL word_rd23: got %h want %h", data_out, 32'h12345678); end
    do_write(32'h22, 32'hAAAAAAAA, 2'b00);
    set_addr(32'h20);
    checks++;
    if (data_out !== 32'hAAAAAAAA) begin errors++; $display("FAIL word_misaligned: got %h want %h", data_out, 32'hAAAAAAAA); end
    do_write(32'h61, 32'h87654321, 2'b11);
    set_addr(32'h60);
    checks++;
    if (data_out !== 32'h87654321) begin errors++; $display("FAIL word_reserved11: got %h want %h", data_out, 32'h87654321); end
  endtask

  task automatic test_byte_lanes();
    do_write(32'h30, 32'hFFFFFF11, 2'b10);
    set_addr(32'h30);
    checks++;
    if (data_out !== 32'h00000011) begin errors++; $display("FAIL byte_lane0: got %h want %h", data_out, 32'h00000011); end
    do_write(32'h31, 32'hFFFFFF22, 2'b10);
    do_write(32'h32, 32'hFFFFFF33, 2'b10);
    set_addr(32'h30);
    checks++;
    if (data_out !== 32'h00332211) begin errors++; $display("FAIL byte_lane012: got %h want %h", data_out, 32'h00332211); end
    do_write(32'h33, 32'hFFFFFF44, 2'b10);
    set_addr(32'h30);
    checks++;
    if (data_out !== 32'h44332211) begin errors++; $display("FAIL byte_all: got %h want %h", data_out, 32'h44332211); end
    set_addr(32'h34);
    checks++;
    if (data_out !== 32'h0) begin errors++; $display("FAIL byte_neighbour: got %h want %h", data_out, 32'h0); end
  endtask

  task automatic test_half_lanes();
    do_write(32'h40, 32'hFFFFFFFF, 2'b00);
    do_write(32'h42, 32'hABCD1234, 2'b01);
    set_addr(32'h40);
    checks++;
    if (data_out !== 32'h1234FFFF) begin errors++; $display("FAIL half_upper: got %h want %h", data_out, 32'h1234FFFF); end
    do_write(32'h40, 32'h00005678, 2'b01);
    set_addr(32'h40);
    checks++;
    if (data_out !== 32'h12345678) begin errors++; $display("FAIL half_lower: got %h want %h", data_out, 32'h12345678); end
    do_write(32'h41, 32'hFFFF9ABC, 2'b01);
    set_addr(32'h40);
    checks++;
    if (data_out !== 32'h12349ABC) begin errors++; $display("FAIL half_lower_odd: got %h want %h", data_out, 32'h12349ABC); end
  endtask

  task automatic test_gating();
    addr = 32'h50; data_in = 32'h99999999; mem_wr = 1'b0;
    for (int m = 0; m < 4; m++) begin
      mux_store = 2'(m);
      @(posedge clk);
      #1;
      checks++;
      if (data_out !== 32'h0) begin errors++; $display("FAIL gate_wr0_ms%0d: got %h want %h", m, data_out, 32'h0); end
    end
    @(negedge clk);
    rst_n = 1'b0;
    addr = 32'h50; data_in = 32'h77777777; mux_store = 2'b00; mem_wr = 1'b1;
    @(posedge clk);
    #1;
    mem_wr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (data_out !== 32'h0) begin errors++; $display("FAIL gate_reset_wr: got %h want %h", data_out, 32'h0); end
    set_addr(32'h40);
    checks++;
    if (data_out !== 32'h0) begin errors++; $display("FAIL gate_reset_clears: got %h want %h", data_out, 32'h0); end
  endtask

  task automatic test_wrap_rdw();
    @(negedge clk);
    addr = 32'h400; data_in = 32'hCAFEF00D; mux_store = 2'b00; mem_wr = 1'b1;
    #1;
    checks++;
    if (data_out !== 32'h0) begin errors++; $display("FAIL rdw_old: got %h want %h", data_out, 32'h0); end
    @(posedge clk);
    #1;
    mem_wr = 1'b0;
    checks++;
    if (data_out !== 32'hCAFEF00D) begin errors++; $display("FAIL rdw_new: got %h want %h", data_out, 32'hCAFEF00D); end
    set_addr(32'h000);
    checks++;
    if (data_out !== 32'hCAFEF00D) begin errors++; $display("FAIL wrap_rd0: got %h want %h", data_out, 32'hCAFEF00D); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    do_write(32'h70, 32'hFFFFFF11, 2'b10);
    do_write(32'h70, 32'hEEEE2233, 2'b01);
    do_write(32'h73, 32'hDDDDDD44, 2'b10);
    do_write(32'h72, 32'hCCCCCC55, 2'b10);
    set_addr(32'h70);
    checks++;
    if (data_out !== 32'h44552233) begin errors++; $display("FAIL b2b_merge: got %h want %h", data_out, 32'h44552233); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_lanes();
    test_half_lanes();
    test_gating();
    test_wrap_rdw();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
